// File: rtl/mmio_gpio_if.sv
// mmio_gpio_if: MEM-stage load/store bus between the pipeline and a memory-mapped peripheral
//   mem_addr/mem_wdata/mem_we/mem_re  master -> slave  byte address, store data, store and load strobes
//   mem_hit/mem_rdata                 slave -> master  window decode and combinational read data
interface mmio_gpio_if;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic        mem_we;
   logic        mem_re;
   logic        mem_hit;
   logic [31:0] mem_rdata;
   modport master (output mem_addr, mem_wdata, mem_we, mem_re, input mem_hit, mem_rdata);
   modport slave (input mem_addr, mem_wdata, mem_we, mem_re, output mem_hit, mem_rdata);
endinterface

// File: rtl/mmio_gpio.sv
// mmio_gpio: memory-mapped GPIO with synchronised, debounced, edge-captured switches and LED registers
//   clk, rst   clock and synchronous active-high reset
//   bus        MEM-stage slave port (addr, wdata, we, re in; hit, rdata out)
//   switches   raw asynchronous switch inputs
//   leds       registered LED drive
//   debug_led  registered debug LED (level or hardware blink)
//   irq        registered OR of the sticky rising-edge flags
module mmio_gpio #(
   parameter logic [31:0] BASE_ADDR       = 32'h0000_1000,
   parameter int          NUM_IO          = 4,
   parameter int          DEBOUNCE_CYCLES = 4,
   parameter int          BLINK_DIV       = 8
) (
   input  logic              clk,
   input  logic              rst,
   mmio_gpio_if.slave        bus,
   input  logic [NUM_IO-1:0] switches,
   output logic [NUM_IO-1:0] leds,
   output logic              debug_led,
   output logic              irq
);
   localparam int DW = $clog2(DEBOUNCE_CYCLES);
   localparam int BW = $clog2(BLINK_DIV);
   localparam logic [DW-1:0] DMAX = DW'(DEBOUNCE_CYCLES - 1);
   localparam logic [BW-1:0] BMAX = BW'(BLINK_DIV - 1);

   logic              hit, wr, blink_run, blink_wrap;
   logic [1:0]        sel;
   logic [NUM_IO-1:0] clr;
   logic [NUM_IO-1:0] s1_q, s1_d, s2_q, s2_d, deb_q, deb_d, flag_q, flag_d, led_q, led_d;
   logic [DW-1:0]     dcnt_q [NUM_IO];
   logic [DW-1:0]     dcnt_d [NUM_IO];
   logic [BW-1:0]     bcnt_q, bcnt_d;
   logic              level_q, level_d, blink_q, blink_d, phase_q, phase_d;
   logic              debug_led_q, debug_led_d, irq_q, irq_d;
   logic              addr_unused;

   assign addr_unused = ^{bus.mem_addr[1:0], bus.mem_wdata[31:NUM_IO]};
   assign leds = led_q;
   assign debug_led = debug_led_q;
   assign irq = irq_q;

   always_comb begin
      hit = bus.mem_addr[31:4] == BASE_ADDR[31:4];
      sel = bus.mem_addr[3:2];
      wr = hit && bus.mem_we;
      s1_d = switches;
      s2_d = s1_q;
      led_d = wr && sel == 2'd1 ? bus.mem_wdata[NUM_IO-1:0] : led_q;
      level_d = wr && sel == 2'd3 ? bus.mem_wdata[0] : level_q;
      blink_d = wr && sel == 2'd3 ? bus.mem_wdata[1] : blink_q;
      clr = wr && sel == 2'd2 ? bus.mem_wdata[NUM_IO-1:0] : '0;
      // A bit flips only after DEBOUNCE_CYCLES consecutive samples disagree with it.
      for (int i = 0; i < NUM_IO; i++) begin
         deb_d[i] = s2_q[i] != deb_q[i] && dcnt_q[i] == DMAX ? s2_q[i] : deb_q[i];
         dcnt_d[i] = s2_q[i] != deb_q[i] && dcnt_q[i] != DMAX ? dcnt_q[i] + 1'b1 : '0;
      end
      // Set beats clear so a rise coinciding with a W1C is never lost.
      flag_d = (flag_q & ~clr) | (deb_d & ~deb_q);
      irq_d = |flag_d;
      // Counting only runs once blink_en has been registered, and any write clearing it
      // zeroes counter and phase on that same edge.
      blink_run = blink_q && blink_d;
      blink_wrap = bcnt_q == BMAX;
      bcnt_d = blink_run && !blink_wrap ? bcnt_q + 1'b1 : '0;
      phase_d = blink_run ? phase_q ^ blink_wrap : 1'b0;
      debug_led_d = blink_d ? phase_d : level_d;
      bus.mem_hit = hit;
      bus.mem_rdata = !(hit && bus.mem_re) ? '0 :
                      sel == 2'd0 ? 32'(deb_q) :
                      sel == 2'd1 ? 32'(led_q) :
                      sel == 2'd2 ? 32'(flag_q) : {30'b0, blink_q, level_q};
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         s1_q <= '0;
         s2_q <= '0;
         deb_q <= '0;
         dcnt_q <= '{default: '0};
         flag_q <= '0;
         led_q <= '0;
         level_q <= 1'b0;
         blink_q <= 1'b0;
         bcnt_q <= '0;
         phase_q <= 1'b0;
         debug_led_q <= 1'b0;
         irq_q <= 1'b0;
      end else begin
         s1_q <= s1_d;
         s2_q <= s2_d;
         deb_q <= deb_d;
         dcnt_q <= dcnt_d;
         flag_q <= flag_d;
         led_q <= led_d;
         level_q <= level_d;
         blink_q <= blink_d;
         bcnt_q <= bcnt_d;
         phase_q <= phase_d;
         debug_led_q <= debug_led_d;
         irq_q <= irq_d;
      end
   end
endmodule

// File: tb/tb_mmio_gpio.sv
// tb_mmio_gpio: directed and randomized checks of mmio_gpio against a behavioural register/switch model
module tb_mmio_gpio;
   logic       clk = 1'b0;
   logic       rst;
   logic [3:0] sw;
   logic [3:0] leds;
   logic       debug_led, irq;
   int         errors = 0;
   int         checks = 0;

   mmio_gpio_if bus ();

   mmio_gpio dut (.clk(clk), .rst(rst), .bus(bus), .switches(sw), .leds(leds), .debug_led(debug_led), .irq(irq));

   always #5 clk = ~clk;

   // Behavioural model: hist[n] is the raw switch value sampled n edges ago; a debounced bit
   // takes a new value once the samples from 2..5 edges ago all agree on it.
   logic [3:0] hist [6];
   logic [3:0] m_deb, m_flags, m_led;
   logic       m_level, m_blink, m_dbl, m_irq, m_valid;
   int         m_age;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic model_edge(input logic r, input logic [31:0] a, input logic [31:0] d, input logic we, input logic [3:0] s);
      logic       wr, old_blink;
      logic [3:0] nd;
      if (r) begin
         for (int k = 0; k < 6; k++) hist[k] = '0;
         {m_deb, m_flags, m_led, m_level, m_blink, m_dbl, m_irq} = '0;
         m_age = 0;
      end else begin
         wr = a[31:4] == 28'h000_0100 && we;
         for (int k = 5; k > 0; k--) hist[k] = hist[k-1];
         hist[0] = s;
         nd = m_deb;
         for (int i = 0; i < 4; i++)
            if (hist[2][i] != m_deb[i] && hist[3][i] != m_deb[i] && hist[4][i] != m_deb[i] && hist[5][i] != m_deb[i])
               nd[i] = ~m_deb[i];
         m_flags = (wr && a[3:2] == 2'd2) ? m_flags & ~d[3:0] : m_flags;
         m_flags = m_flags | (nd & ~m_deb);
         m_deb = nd;
         m_irq = |m_flags;
         if (wr && a[3:2] == 2'd1) m_led = d[3:0];
         old_blink = m_blink;
         if (wr && a[3:2] == 2'd3) {m_blink, m_level} = d[1:0];
         m_age = (m_blink && old_blink) ? m_age + 1 : 0;
         m_dbl = m_blink ? ((m_age / 8) % 2 == 1) : m_level;
      end
      m_valid = 1'b1;
   endtask

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic re);
      if (a[31:4] != 28'h000_0100 || !re) return 32'h0;
      case (a[3:2])
         2'd0: return {28'h0, m_deb};
         2'd1: return {28'h0, m_led};
         2'd2: return {28'h0, m_flags};
         default: return {30'h0, m_blink, m_level};
      endcase
   endfunction

   task automatic cyc(input logic r, input logic [31:0] a, input logic [31:0] d, input logic we, input logic re, input logic [3:0] s);
      rst = r;
      bus.mem_addr = a;
      bus.mem_wdata = d;
      bus.mem_we = we;
      bus.mem_re = re;
      sw = s;
      #1;
      if (m_valid) begin
         chk("hit", {31'h0, bus.mem_hit}, {31'h0, a[31:4] == 28'h000_0100});
         chk("rdata", bus.mem_rdata, m_read(a, re));
      end
      @(posedge clk);
      model_edge(r, a, d, we, s);
      #1;
      chk("leds", {28'h0, leds}, {28'h0, m_led});
      chk("debug_led", {31'h0, debug_led}, {31'h0, m_dbl});
      chk("irq", {31'h0, irq}, {31'h0, m_irq});
   endtask

   task automatic idle(input int n, input logic [3:0] s, input logic [31:0] a);
      for (int k = 0; k < n; k++) cyc(1'b0, a, 32'h0, 1'b0, 1'b1, s);
   endtask

   task automatic store(input logic [31:0] a, input logic [31:0] d, input logic [3:0] s);
      cyc(1'b0, a, d, 1'b1, 1'b0, s);
   endtask

   initial begin
      logic [31:0] a;
      logic [3:0]  rs;
      m_valid = 1'b0;
      // Reset with switches high: nothing may leak through.
      cyc(1'b1, 32'h1000, 32'h0, 1'b0, 1'b1, 4'hF);
      cyc(1'b1, 32'h1000, 32'h0, 1'b0, 1'b1, 4'hF);
      chk("rst_sw_state", bus.mem_rdata, 32'h0);
      chk("rst_leds", {28'h0, leds}, 32'h0);
      idle(8, 4'h0, 32'h1000);
      // LED register and out-of-window store.
      store(32'h1004, 32'h5, 4'h0);
      chk("led_out", {28'h0, leds}, 32'h5);
      idle(1, 4'h0, 32'h1004);
      chk("led_read", bus.mem_rdata, 32'h5);
      store(32'h2004, 32'hF, 4'h0);
      chk("led_outside", {28'h0, leds}, 32'h5);
      chk("hit_outside", {31'h0, bus.mem_hit}, 32'h0);
      // Switch 0 rises; SW_STATE polled every cycle around the k+5 boundary.
      idle(8, 4'h1, 32'h1000);
      chk("deb_sw0", bus.mem_rdata, 32'h1);
      idle(1, 4'h1, 32'h1008);
      chk("edge_sw0", bus.mem_rdata, 32'h1);
      chk("irq_sw0", {31'h0, irq}, 32'h1);
      // Three-cycle glitch on switch 1 must be rejected.
      idle(3, 4'h3, 32'h1000);
      idle(8, 4'h1, 32'h1000);
      chk("glitch_sw1", bus.mem_rdata, 32'h1);
      store(32'h1008, 32'h1, 4'h1);
      chk("irq_clr", {31'h0, irq}, 32'h0);
      // Release switch 0, then re-press it so the rise lands with a W1C.
      idle(8, 4'h0, 32'h1000);
      idle(5, 4'h1, 32'h1000);
      store(32'h1008, 32'h1, 4'h1);
      chk("set_wins", {31'h0, irq}, 32'h1);
      store(32'h1008, 32'hF, 4'h1);
      // Blink, then level override.
      store(32'h100C, 32'h2, 4'h1);
      idle(20, 4'h1, 32'h100C);
      store(32'h100C, 32'h1, 4'h1);
      chk("dbg_level1", {31'h0, debug_led}, 32'h1);
      idle(2, 4'h1, 32'h100C);
      store(32'h100C, 32'h0, 4'h1);
      chk("dbg_level0", {31'h0, debug_led}, 32'h0);
      // Reset while blinking and with a switch release half-debounced.
      store(32'h100C, 32'h2, 4'h1);
      idle(5, 4'h1, 32'h1000);
      idle(4, 4'h0, 32'h1000);
      cyc(1'b1, 32'h1000, 32'h0, 1'b0, 1'b1, 4'h2);
      chk("rst_dbg", {31'h0, debug_led}, 32'h0);
      idle(8, 4'h2, 32'h1000);
      chk("post_rst_deb", bus.mem_rdata, 32'h2);
      // Randomized traffic.
      rs = 4'h0;
      for (int n = 0; n < 2000; n++) begin
         if ($urandom_range(0, 5) == 0) rs = 4'($urandom);
         case ($urandom_range(0, 5))
            0, 1, 2, 3: a = 32'h1000 + 32'($urandom_range(0, 15));
            4: a = 32'h2000 + 32'($urandom_range(0, 15));
            default: a = $urandom;
         endcase
         cyc($urandom_range(0, 150) == 0, a, $urandom, $urandom_range(0, 3) == 0, 1'($urandom), rs);
      end
      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule

// File: doc/mmio_gpio.md
Name: mmio_gpio

Overview:
Memory-mapped GPIO peripheral directly downstream of the MEM stage. It decodes MEM-stage load/store accesses that fall inside its address window and exposes the board switches and LEDs as registers. Switch inputs are synchronised, debounced and edge-captured. LED and debug-LED outputs are driven from writable registers, with an optional hardware blink mode on the debug LED.

Parameters:
BASE_ADDR, 32'h0000_1000, base of 16-byte register window; bits [3:0] must be zero
NUM_IO, 4, number of switches and LEDs
DEBOUNCE_CYCLES, 4, consecutive stable cycles required to accept a switch change (>=2)
BLINK_DIV, 8, cycles per debug-LED toggle in blink mode (>=2)

Ports:
clk  in  1  system clock; single clock domain
rst  in  1  reset; synchronous, active-high
mem_addr  in  32  MEM-stage byte address
mem_wdata  in  32  MEM-stage store data
mem_we  in  1  store strobe
mem_re  in  1  load strobe
mem_hit  out  1  combinational; 1 when mem_addr[31:4]==BASE_ADDR[31:4]
mem_rdata  out  32  combinational read data; 0 when !mem_hit or !mem_re
switches  in  NUM_IO  raw asynchronous board switches
leds  out  NUM_IO  LED drive, registered
debug_led  out  1  debug LED, registered
irq  out  1  OR of all edge flags, registered

Behaviour:
- Register map, selected by mem_addr[3:2]; mem_addr[1:0] ignored; word accesses only:
  - 0x0 SW_STATE (RO): [NUM_IO-1:0] = debounced switches.
  - 0x4 LED (RW): [NUM_IO-1:0] drives leds.
  - 0x8 SW_EDGE (RW1C): sticky rising-edge flags.
  - 0xC DEBUG (RW): bit0 = dbg_level, bit1 = blink_en.
  - Unused bits read 0.
- Writes: take effect at the clk edge where mem_hit && mem_we. Writes to SW_STATE are ignored. Outputs reflect the new value the cycle after.
- Reads: combinational from current register state, with no side effects. When mem_we and mem_re are both asserted, mem_rdata shows the pre-write value.
- Reset: all of the following are 0 — leds, debug_led, irq, LED reg, DEBUG reg, edge flags, sync flops, debounced state, debounce counters, blink counter and blink phase. mem_rdata and mem_hit follow the combinational rules above. Reset mid-debounce discards the partial count.
- Synchroniser: 2 flops per bit (s1 <= switches; s2 <= s1).
- Debounce, per bit, each cycle:
  - If s2 != deb: if cnt == DEBOUNCE_CYCLES-1, then deb <= s2 and cnt <= 0; else cnt <= cnt+1.
  - If s2 == deb: cnt <= 0.
  - A raw change first sampled at edge k becomes visible in deb after edge k+1+DEBOUNCE_CYCLES (k+5 at default).
  - A pulse lasting fewer than DEBOUNCE_CYCLES cycles at s2 never changes deb.
  - Counter width is clog2(DEBOUNCE_CYCLES).
- Edge flags: flag[i] sets on the cycle deb[i] goes 0->1. Writing 1 to SW_EDGE bit i clears it. If set and clear land in the same cycle, set wins. Falling edges are not captured.
- irq <= |flags_next, registered, so it is valid the same cycle the flags update.
- Debug LED:
  - blink_en=0: debug_led <= dbg_level; blink counter and phase held at 0.
  - blink_en=1: counter increments each cycle. At BLINK_DIV-1 it wraps to 0 and phase toggles. debug_led <= phase, so the first toggle comes BLINK_DIV cycles after enable.
  - Clearing blink_en resets counter and phase in the same cycle.
- No wait states: every access completes in the cycle it is presented. Accesses outside the window have no effect.

Test Plan:
- Reset: rst=1 for 2 cycles with switches=4'hF -> leds=0, debug_led=0, irq=0, SW_STATE reads 0 during reset.
- LED write: store 0x0000_0005 to 0x1004 -> leds=4'b0101 the next cycle; load 0x1004 returns 0x5. Store to 0x2004 -> leds unchanged, mem_hit=0.
- Debounce: switches 0->4'b0001 sampled at edge k -> SW_STATE reads 0x1 from edge k+5, not before. A 3-cycle pulse on switches[1] -> SW_STATE bit1 stays 0, no flag.
- Edge/irq: after SW0 rises, SW_EDGE reads 0x1 and irq=1. Store 0x1 to 0x1008 -> flag clears and irq=0 next cycle. A new rising edge in the same cycle as the clear -> flag stays 1.
- Blink: store 0x2 to 0x100C -> debug_led toggles every 8 cycles (high cycles 9-16). Store 0x1 -> debug_led=1 steady next cycle. Store 0x0 -> debug_led=0.
- Reset mid-op: assert rst while the debounce count is at 2 and blink is active -> all state returns to 0; after release, a held switch needs the full 2+4 cycles to register.
